// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states
// and the default datapath width.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MADDU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the pipeline control and the multiply/divide unit.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, op, opA, opB, hi_we, lo_we, wdata,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, op, opA, opB, hi_we, lo_we, wdata,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/mdu_iter_core.sv
// Radix-2 iterative datapath on unsigned magnitudes: shift-add multiply or
// restoring shift-subtract divide, one step per asserted step cycle.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             mode_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;

    always_comb begin
        add_sum  = {1'b0, acc} + {1'b0, operand_b};
        rem_sh   = {acc, sh[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, operand_b};
    end

    // Multiply: {acc,sh} shifts right, multiplier bits leave through sh[0].
    // Divide: dividend bits leave sh[MSB] into acc, quotient bits enter sh[0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            sh        <= '0;
            operand_b <= '0;
        end else if (load) begin
            acc       <= '0;
            sh        <= a_in;
            operand_b <= b_in;
        end else if (step) begin
            if (!mode_div) begin
                if (sh[0]) {acc, sh} <= {add_sum, sh[WIDTH-1:1]};
                else       {acc, sh} <= {1'b0, acc, sh[WIDTH-1:1]};
            end else if (!rem_diff[WIDTH]) begin
                acc <= rem_diff[WIDTH-1:0];
                sh  <= {sh[WIDTH-2:0], 1'b1};
            end else begin
                acc <= rem_sh[WIDTH-1:0];
                sh  <= {sh[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign hi = acc;
    assign lo = sh;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO; FSM, sign handling and MTHI/MTLO.
// Optional multiply-accumulate (MADD/MADDU) enabled by defining MDU_MADD_EN.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input logic  CLK,
    input logic  RST,
    mdu_if.slave bus
);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi, lo, a_raw;
    logic [WIDTH-1:0]   a_mag, b_mag, core_hi, core_lo, quo, rem;
    logic [2*WIDTH-1:0] mul_res;
    logic               mode_div, neg_res, neg_rem, div_zero;
    logic               legal, signed_op, accept, step, calc_end, busy;
`ifdef MDU_MADD_EN
    logic               acc_mode;
`endif

    always_comb begin
        legal     = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                    (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
`ifdef MDU_MADD_EN
        legal     = legal || (bus.op == OP_MADD) || (bus.op == OP_MADDU);
        signed_op = signed_op || (bus.op == OP_MADD);
`endif
        a_mag = (signed_op && bus.opA[WIDTH-1]) ? -bus.opA : bus.opA;
        b_mag = (signed_op && bus.opB[WIDTH-1]) ? -bus.opB : bus.opB;
    end

    assign busy     = (state == S_CALC) || (state == S_FIX);
    assign accept   = bus.start && legal && ((state == S_IDLE) || (state == S_DONE));
    assign calc_end = (cnt == CNT_W'(WIDTH));
    assign step     = (state == S_CALC) && !calc_end;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_CALC;
            S_CALC:  if (calc_end) state_nx = S_FIX;
            S_FIX:   state_nx = S_DONE;
            S_DONE:  state_nx = accept ? S_CALC : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt      <= '0;
            mode_div <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
`ifdef MDU_MADD_EN
            acc_mode <= 1'b0;
`endif
        end else if (accept) begin
            cnt      <= '0;
            mode_div <= (bus.op == OP_DIV) || (bus.op == OP_DIVU);
            neg_res  <= signed_op && (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
            neg_rem  <= signed_op && bus.opA[WIDTH-1];
            div_zero <= (bus.opB == '0);
            a_raw    <= bus.opA;
`ifdef MDU_MADD_EN
            acc_mode <= (bus.op == OP_MADD) || (bus.op == OP_MADDU);
`endif
        end else if (state == S_CALC) begin
            cnt <= cnt + 1'b1;
        end
    end

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (CLK),
        .rst      (RST),
        .load     (accept),
        .step     (step),
        .mode_div ((bus.op == OP_DIV) || (bus.op == OP_DIVU) ? accept | mode_div : mode_div & ~accept),
        .a_in     (a_mag),
        .b_in     (b_mag),
        .hi       (core_hi),
        .lo       (core_lo)
    );

    // Signs are re-applied once, on the unsigned magnitudes the core produced.
    always_comb begin
        mul_res = neg_res ? -{core_hi, core_lo} : {core_hi, core_lo};
`ifdef MDU_MADD_EN
        if (acc_mode) mul_res = mul_res + {hi, lo};
`endif
        quo = neg_res ? -core_lo : core_lo;
        rem = neg_rem ? -core_hi : core_hi;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hi <= '0;
            lo <= '0;
        end else if (state == S_FIX) begin
            if (!mode_div) begin
                {hi, lo} <= mul_res;
            end else if (div_zero) begin
                hi <= a_raw;
                lo <= '1;
            end else begin
                hi <= rem;
                lo <= quo;
            end
        end else if (!busy && !accept) begin
            if (bus.hi_we) hi <= bus.wdata;
            if (bus.lo_we) lo <= bus.wdata;
        end
    end

    assign bus.busy = busy;
    assign bus.done = (state == S_DONE);
    assign bus.HI   = hi;
    assign bus.LO   = lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized
// operations against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clk;
    logic rst;
    int   passed = 0;
    int   total  = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mdu_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] prior);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: r = 64'(sa * sb);
            3'd1: r = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else r = {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
            3'd4: r = prior + 64'(sa * sb);
            3'd5: r = prior + {32'd0, a} * {32'd0, b};
            default: r = prior;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.opA   = a;
        bus.opB   = b;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (bus.done !== 1'b1 && edges < 100) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.opA = '0; bus.opB = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        #2;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else passed++;
        total++; if (bus.HI !== 32'd0) $display("FAIL reset_hi: got %h want 0", bus.HI); else passed++;
        total++; if (bus.LO !== 32'd0) $display("FAIL reset_lo: got %h want 0", bus.LO); else passed++;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_latency;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int k = 1; k <= 34; k++) begin
            tick();
            total++;
            if (bus.busy !== (k <= 33)) $display("FAIL lat_busy_e%0d: got %b want %b", k, bus.busy, (k <= 33));
            else passed++;
            total++;
            if (bus.done !== (k == 34)) $display("FAIL lat_done_e%0d: got %b want %b", k, bus.done, (k == 34));
            else passed++;
        end
        exp_hi = 32'hFFFF_FFFE; exp_lo = 32'h0000_0001;
        total++; if (bus.HI !== exp_hi) $display("FAIL multu_hi: got %h want %h", bus.HI, exp_hi); else passed++;
        total++; if (bus.LO !== exp_lo) $display("FAIL multu_lo: got %h want %h", bus.LO, exp_lo); else passed++;
        tick();
        total++; if (bus.done !== 1'b0) $display("FAIL done_pulse: got %b want 0", bus.done); else passed++;
    endtask

    task automatic test_signed;
        int e;
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(e);
        total++; if (e != 34) $display("FAIL mult_latency: got %0d want 34", e); else passed++;
        total++; if (bus.HI !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h want ffffffff", bus.HI); else passed++;
        total++; if (bus.LO !== 32'hFFFF_FFEB) $display("FAIL mult_lo: got %h want ffffffeb", bus.LO); else passed++;
        tick();
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(e);
        total++; if (bus.LO !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h want fffffffd", bus.LO); else passed++;
        total++; if (bus.HI !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h want ffffffff", bus.HI); else passed++;
        exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFD;
        tick();
    endtask

    task automatic test_div_corner;
        int e;
        issue(OP_DIVU, 32'd100, 32'd0);
        wait_done(e);
        total++; if (bus.LO !== 32'hFFFF_FFFF) $display("FAIL divu0_lo: got %h want ffffffff", bus.LO); else passed++;
        total++; if (bus.HI !== 32'd100) $display("FAIL divu0_hi: got %h want 00000064", bus.HI); else passed++;
        tick();
        issue(OP_DIV, 32'hFFFF_FFF0, 32'd0);
        wait_done(e);
        total++; if (bus.LO !== 32'hFFFF_FFFF) $display("FAIL div0_lo: got %h want ffffffff", bus.LO); else passed++;
        total++; if (bus.HI !== 32'hFFFF_FFF0) $display("FAIL div0_hi: got %h want fffffff0", bus.HI); else passed++;
        tick();
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(e);
        total++; if (bus.LO !== 32'h8000_0000) $display("FAIL divovf_lo: got %h want 80000000", bus.LO); else passed++;
        total++; if (bus.HI !== 32'd0) $display("FAIL divovf_hi: got %h want 0", bus.HI); else passed++;
        exp_hi = 32'd0; exp_lo = 32'h8000_0000;
        tick();
    endtask

    task automatic test_mthi_mtlo;
        bus.hi_we = 1'b1; bus.wdata = 32'h1234;
        tick();
        bus.hi_we = 1'b0;
        total++; if (bus.HI !== 32'h1234) $display("FAIL mthi: got %h want 00001234", bus.HI); else passed++;
        total++; if (bus.LO !== exp_lo) $display("FAIL mthi_lo_hold: got %h want %h", bus.LO, exp_lo); else passed++;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5_5A5A;
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        exp_hi = 32'hA5A5_5A5A; exp_lo = 32'hA5A5_5A5A;
        total++; if (bus.HI !== exp_hi) $display("FAIL both_we_hi: got %h want %h", bus.HI, exp_hi); else passed++;
        total++; if (bus.LO !== exp_lo) $display("FAIL both_we_lo: got %h want %h", bus.LO, exp_lo); else passed++;
    endtask

    task automatic test_ignore_while_busy;
        int e;
        issue(OP_DIVU, 32'd10, 32'd3);
        repeat (4) tick();
        bus.start = 1'b1; bus.op = OP_MULTU; bus.opA = 32'd9; bus.opB = 32'd9;
        bus.lo_we = 1'b1; bus.wdata = 32'h55;
        tick();
        bus.start = 1'b0; bus.lo_we = 1'b0;
        total++; if (bus.LO !== exp_lo) $display("FAIL busy_lo_hold: got %h want %h", bus.LO, exp_lo); else passed++;
        total++; if (bus.busy !== 1'b1) $display("FAIL busy_mid: got %b want 1", bus.busy); else passed++;
        wait_done(e);
        total++; if (e != 29) $display("FAIL busy_ignore_latency: got %0d want 29", e); else passed++;
        total++; if (bus.HI !== 32'd1) $display("FAIL busy_ignore_hi: got %h want 1", bus.HI); else passed++;
        total++; if (bus.LO !== 32'd3) $display("FAIL busy_ignore_lo: got %h want 3", bus.LO); else passed++;
        exp_hi = 32'd1; exp_lo = 32'd3;
        tick();
        total++; if (bus.busy !== 1'b0) $display("FAIL busy_ignore_idle: got %b want 0", bus.busy); else passed++;
    endtask

    task automatic test_back_to_back;
        int e;
        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        wait_done(e);
        total++; if (bus.HI !== 32'd1) $display("FAIL b2b1_hi: got %h want 1", bus.HI); else passed++;
        total++; if (bus.LO !== 32'd0) $display("FAIL b2b1_lo: got %h want 0", bus.LO); else passed++;
        bus.hi_we = 1'b1; bus.wdata = 32'hDEAD;
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10);
        bus.hi_we = 1'b0;
        total++; if (bus.busy !== 1'b1) $display("FAIL b2b_accept: got %b want 1", bus.busy); else passed++;
        total++; if (bus.HI !== 32'd1) $display("FAIL b2b_start_wins: got %h want 1", bus.HI); else passed++;
        wait_done(e);
        total++; if (e != 34) $display("FAIL b2b2_latency: got %0d want 34", e); else passed++;
        total++; if (bus.HI !== 32'hF) $display("FAIL b2b2_hi: got %h want f", bus.HI); else passed++;
        total++; if (bus.LO !== 32'h0FFF_FFFF) $display("FAIL b2b2_lo: got %h want 0fffffff", bus.LO); else passed++;
        exp_hi = 32'hF; exp_lo = 32'h0FFF_FFFF;
        tick();
    endtask

    task automatic test_illegal;
        logic [2:0] ops [3];
        ops[0] = 3'd6; ops[1] = 3'd7;
`ifdef MDU_MADD_EN
        ops[2] = 3'd7;
`else
        ops[2] = OP_MADD;
`endif
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], 32'd5, 32'd5);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (bus.busy !== 1'b0) $display("FAIL illegal_op%0d_busy: got %b want 0", ops[i], bus.busy);
                else passed++;
                tick();
            end
            total++; if (bus.HI !== exp_hi) $display("FAIL illegal_hi: got %h want %h", bus.HI, exp_hi); else passed++;
            total++; if (bus.LO !== exp_lo) $display("FAIL illegal_lo: got %h want %h", bus.LO, exp_lo); else passed++;
        end
    endtask

`ifdef MDU_MADD_EN
    task automatic test_madd;
        int e;
        bus.hi_we = 1'b1; bus.wdata = 32'd0;
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'hFFFF_FFFF;
        tick();
        bus.lo_we = 1'b0;
        issue(OP_MADDU, 32'd1, 32'd1);
        wait_done(e);
        total++; if (e != 34) $display("FAIL maddu_latency: got %0d want 34", e); else passed++;
        total++; if (bus.HI !== 32'd1) $display("FAIL maddu_hi: got %h want 1", bus.HI); else passed++;
        total++; if (bus.LO !== 32'd0) $display("FAIL maddu_lo: got %h want 0", bus.LO); else passed++;
        exp_hi = 32'd1; exp_lo = 32'd0;
        tick();
    endtask
`endif

    task automatic test_random;
        int e;
        logic [2:0]  o;
        logic [31:0] a, b, w;
        for (int i = 0; i < 20; i++) begin
`ifdef MDU_MADD_EN
            o = 3'($urandom_range(0, 5));
`else
            o = 3'($urandom_range(0, 3));
`endif
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: a = 32'h8000_0000;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                w = $urandom;
                bus.lo_we = 1'b1; bus.wdata = w;
                tick();
                bus.lo_we = 1'b0;
                exp_lo = w;
            end
            {exp_hi, exp_lo} = ref_result(o, a, b, {exp_hi, exp_lo});
            issue(o, a, b);
            wait_done(e);
            total++; if (e != 34) $display("FAIL rnd%0d_latency: got %0d want 34", i, e); else passed++;
            total++;
            if (bus.HI !== exp_hi) $display("FAIL rnd%0d_hi op%0d a=%h b=%h: got %h want %h", i, o, a, b, bus.HI, exp_hi);
            else passed++;
            total++;
            if (bus.LO !== exp_lo) $display("FAIL rnd%0d_lo op%0d a=%h b=%h: got %h want %h", i, o, a, b, bus.LO, exp_lo);
            else passed++;
            if ($urandom_range(0, 1) == 0) tick();
        end
        tick();
    endtask

    task automatic test_async_reset;
        bus.hi_we = 1'b1; bus.wdata = 32'h1234;
        tick();
        bus.hi_we = 1'b0;
        total++; if (bus.HI !== 32'h1234) $display("FAIL pre_reset_mthi: got %h want 00001234", bus.HI); else passed++;
        issue(OP_MULTU, 32'd2, 32'd3);
        repeat (9) tick();
        #2 rst = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL areset_busy: got %b want 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL areset_done: got %b want 0", bus.done); else passed++;
        total++; if (bus.HI !== 32'd0) $display("FAIL areset_hi: got %h want 0", bus.HI); else passed++;
        total++; if (bus.LO !== 32'd0) $display("FAIL areset_lo: got %h want 0", bus.LO); else passed++;
        tick();
        rst = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        repeat (3) tick();
        total++; if (bus.busy !== 1'b0) $display("FAIL areset_abort_busy: got %b want 0", bus.busy); else passed++;
        total++; if (bus.HI !== 32'd0) $display("FAIL areset_abort_hi: got %h want 0", bus.HI); else passed++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_signed();
        test_div_corner();
        test_mthi_mtlo();
        test_ignore_while_busy();
        test_back_to_back();
        test_illegal();
`ifdef MDU_MADD_EN
        test_madd();
`endif
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
